imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Write-side counterpart of the instruction memory. The CPU datapath only ever reads IMEM, addressed by PC.
- Accepts a byte stream over a valid/ready handshake, typically switch-entered bytes with the load button debounced upstream.
- Packs bytes big-endian into 32-bit instruction words and issues one-cycle write strobes to IMEM at incrementing addresses.
- Holds the CPU (PC) in reset for the whole load session.

Parameters:
- ADDR_W, 8: IMEM word-address width, matching the 8-bit PC.
- BYTES_PER_WORD, 4: bytes per instruction word. Fixed; not intended to be overridden.

Ports:
- SYS_clk, in, 1: system clock.
- SYS_rst, in, 1: reset, synchronous, active-high.
- LD_start, in, 1: single-cycle pulse that opens a load session. Ignored unless in IDLE.
- LD_base_addr, in, ADDR_W: first IMEM word address, sampled on LD_start.
- LD_byte, in, 8: incoming byte.
- LD_byte_valid, in, 1: LD_byte is valid.
- LD_byte_ready, out, 1: loader accepts a byte this cycle.
- LD_done, in, 1: single-cycle pulse that closes the session.
- LD_wr_en, out, 1: IMEM write strobe, one cycle per word.
- LD_wr_addr, out, ADDR_W: IMEM write address.
- LD_wr_data, out, 32: IMEM write data.
- LD_cpu_hold, out, 1: OR'd into the PC reset by the system.
- LD_busy, out, 1: high in any state other than IDLE.
- LD_word_count, out, ADDR_W+1: words written in the current or last session.
- LD_err, out, 1: sticky until the next LD_start. Set on a partial final word or on address overflow.

Behaviour:
- Clock and reset: one clock (SYS_clk). Reset is synchronous, active-high (SYS_rst), and takes priority over everything.
- Reset values: state=IDLE; LD_byte_ready=0, LD_wr_en=0, LD_wr_addr=0, LD_wr_data=0, LD_cpu_hold=0, LD_busy=0, LD_word_count=0, LD_err=0; internal byte_cnt=0, shift=0, done_pend=0.
- Reset mid-session: the partial word is discarded, no write is issued, and LD_cpu_hold drops the cycle after reset is sampled.
- A byte is accepted when LD_byte_valid & LD_byte_ready. On accept: shift <= {shift[23:0], LD_byte} and byte_cnt increments. The first byte received is bits [31:24].
- States:
  - IDLE: ready=0, hold=0.
    - LD_start -> COLLECT: addr<=LD_base_addr, byte_cnt<=0, shift<=0, LD_word_count<=0, LD_err<=0, done_pend<=0.
  - COLLECT: ready=1, hold=1.
    - Fourth byte accepted -> WRITE. If LD_done is in the same cycle, set done_pend.
    - LD_done with no completing accept and byte_cnt==0 -> RELEASE.
    - LD_done with no completing accept and byte_cnt!=0 -> FLUSH. A byte accepted in the same cycle is counted before the flush.
  - WRITE: ready=0, one cycle.
    - LD_wr_en=1, LD_wr_addr=addr, LD_wr_data=shift.
    - Then LD_word_count++, byte_cnt<=0.
    - If addr==2^ADDR_W-1: set LD_err and go to RELEASE. No wrap-around.
    - Otherwise addr++ and go to RELEASE if done_pend, else COLLECT.
  - FLUSH: ready=0, one cycle.
    - Write LD_wr_data = shift << 8*(4-byte_cnt), i.e. missing low bytes zero-filled.
    - LD_word_count++, set LD_err, -> RELEASE.
  - RELEASE: ready=0, hold=1 for exactly one cycle so the final IMEM write settles before the PC runs, -> IDLE.
- Latency: the fourth byte accepted in cycle N gives LD_wr_en high in cycle N+1. Sustained throughput is 4 bytes per 5 cycles.
- LD_wr_addr and LD_wr_data are registered and hold their last values outside WRITE/FLUSH.
- LD_start while busy is ignored.
- LD_done in IDLE, WRITE, FLUSH or RELEASE is ignored. A done coincident with a completing byte is the only case latched via done_pend.
- LD_byte_valid with ready=0 leaves state unchanged; the source holds the byte until ready.

Decomposition:
- Shared package:
  - state enum {IDLE, COLLECT, WRITE, FLUSH, RELEASE}.
  - BYTES_PER_WORD=4 and WORD_W=32.
  - The byte-order constant (big-endian).
- Sub-module ld_byte_packer holds the shift register, byte_cnt and the zero-pad function. The FSM stays in imem_loader.

Test Plan:
- Full-word load: start at base 0x10, send bytes 0x20,0x08,0x00,0x05, pulse done -> one write addr=0x10 data=0x20080005. Word_count=1, err=0; hold falls two cycles after the write.
- Multi-word with back-to-back valid: 3 words from base 0x00 -> writes at 0x00/0x01/0x02, each wr_en one cycle after its fourth byte. ready low exactly in the WRITE cycles.
- Partial flush: bytes 0xAB,0xCD then done -> write data=0xABCD0000, err=1, word_count=1.
- Overflow: base 0xFF, send 8 bytes -> one write at 0xFF, err=1, then RELEASE/IDLE. Bytes 5-8 never accepted, no write at 0x00.
- Simultaneous done with fourth byte -> single write, then RELEASE with no extra FLUSH write. Word_count=1, err=0.
- Reset after 2 bytes -> no write, hold=0 and busy=0 next cycle. LD_start while busy does not change the base address.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared states and word-format constants for the IMEM loader
package imem_loader_pkg;
  typedef enum logic [2:0] {IDLE, COLLECT, WRITE, FLUSH, RELEASE} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int WORD_W = 32;
  localparam bit BIG_ENDIAN = 1'b1;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake, IMEM write port and load status of the loader
interface imem_loader_if
  import imem_loader_pkg::*;
#(parameter int ADDR_W = 8);
  logic LD_start;
  logic [ADDR_W-1:0] LD_base_addr;
  logic [7:0] LD_byte;
  logic LD_byte_valid;
  logic LD_byte_ready;
  logic LD_done;
  logic LD_wr_en;
  logic [ADDR_W-1:0] LD_wr_addr;
  logic [WORD_W-1:0] LD_wr_data;
  logic LD_cpu_hold;
  logic LD_busy;
  logic [ADDR_W:0] LD_word_count;
  logic LD_err;
  modport master (
    output LD_start, LD_base_addr, LD_byte, LD_byte_valid, LD_done,
    input LD_byte_ready, LD_wr_en, LD_wr_addr, LD_wr_data, LD_cpu_hold, LD_busy, LD_word_count, LD_err
  );
  modport slave (
    input LD_start, LD_base_addr, LD_byte, LD_byte_valid, LD_done,
    output LD_byte_ready, LD_wr_en, LD_wr_addr, LD_wr_data, LD_cpu_hold, LD_busy, LD_word_count, LD_err
  );
endinterface

// File: rtl/imem_loader_ld_byte_packer.sv
// ld_byte_packer: shifts accepted bytes into a word, counts them and zero-pads a partial word
module ld_byte_packer
  import imem_loader_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_acc,
  input  logic [7:0] i_byte,
  output logic [2:0] o_cnt_nxt,
  output logic [WORD_W-1:0] o_word_nxt,
  output logic [WORD_W-1:0] o_pad_nxt
);
  logic [WORD_W-1:0] r_shift;
  logic [2:0] r_cnt;
  function automatic logic [WORD_W-1:0] zero_pad(input logic [WORD_W-1:0] w, input logic [2:0] n);
    return BIG_ENDIAN ? w << (8 * (BYTES_PER_WORD - int'(n))) : w >> (8 * (BYTES_PER_WORD - int'(n)));
  endfunction
  assign o_word_nxt = !i_acc ? r_shift :
                      BIG_ENDIAN ? {r_shift[WORD_W-9:0], i_byte} : {i_byte, r_shift[WORD_W-1:8]};
  assign o_cnt_nxt = r_cnt + {2'b0, i_acc};
  assign o_pad_nxt = zero_pad(o_word_nxt, o_cnt_nxt);
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_shift <= '0;
      r_cnt <= '0;
    end else begin
      r_shift <= o_word_nxt;
      r_cnt <= o_cnt_nxt;
    end
  end
endmodule

// File: rtl/imem_loader.sv
// imem_loader: packs a byte stream into 32-bit IMEM writes and holds the CPU while loading
module imem_loader
  import imem_loader_pkg::*;
#(parameter int ADDR_W = 8)
(
  input logic SYS_clk,
  input logic SYS_rst,
  imem_loader_if.slave ld
);
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, r_wr_addr;
  logic [WORD_W-1:0] r_wr_data;
  logic [ADDR_W:0] r_word_count;
  logic r_done_pend, r_wr_en, r_err;
  logic w_acc, w_full, w_clr, w_issue;
  logic [2:0] w_cnt_nxt;
  logic [WORD_W-1:0] w_word_nxt, w_pad_nxt;
  assign w_acc = ld.LD_byte_valid && r_state == COLLECT;
  assign w_full = w_acc && w_cnt_nxt == 3'(BYTES_PER_WORD);
  assign w_clr = (r_state == IDLE && ld.LD_start) || r_state == WRITE;
  assign w_issue = r_state == COLLECT && (w_next == WRITE || w_next == FLUSH);
  ld_byte_packer u_packer (
    .clk(SYS_clk),
    .rst(SYS_rst),
    .i_clr(w_clr),
    .i_acc(w_acc),
    .i_byte(ld.LD_byte),
    .o_cnt_nxt(w_cnt_nxt),
    .o_word_nxt(w_word_nxt),
    .o_pad_nxt(w_pad_nxt)
  );
  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE:    w_next = ld.LD_start ? COLLECT : IDLE;
      COLLECT: w_next = w_full ? WRITE : !ld.LD_done ? COLLECT : w_cnt_nxt == 3'd0 ? RELEASE : FLUSH;
      WRITE:   w_next = (r_addr == '1 || r_done_pend) ? RELEASE : COLLECT;
      FLUSH:   w_next = RELEASE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  // write address/data are captured on the issuing edge so they are stable during the strobe
  always_ff @(posedge SYS_clk) begin
    if (SYS_rst) begin
      r_addr <= '0;
      r_wr_en <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_word_count <= '0;
      r_done_pend <= 1'b0;
      r_err <= 1'b0;
    end else begin
      r_wr_en <= w_issue;
      if (r_state == IDLE && ld.LD_start) begin
        r_addr <= ld.LD_base_addr;
        r_word_count <= '0;
        r_err <= 1'b0;
        r_done_pend <= 1'b0;
      end
      if (w_issue) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_full ? w_word_nxt : w_pad_nxt;
        r_done_pend <= ld.LD_done;
      end
      if (r_state == WRITE || r_state == FLUSH) begin
        r_word_count <= r_word_count + 1'b1;
        r_err <= r_err || r_state == FLUSH || r_addr == '1;
      end
      if (r_state == WRITE && r_addr != '1) r_addr <= r_addr + 1'b1;
    end
  end
  assign ld.LD_byte_ready = r_state == COLLECT;
  assign ld.LD_cpu_hold = r_state != IDLE;
  assign ld.LD_busy = r_state != IDLE;
  assign ld.LD_wr_en = r_wr_en;
  assign ld.LD_wr_addr = r_wr_addr;
  assign ld.LD_wr_data = r_wr_data;
  assign ld.LD_word_count = r_word_count;
  assign ld.LD_err = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed and random byte streams checked against a session-level model
module tb_imem_loader;
  logic clk, rst;
  int n_chk, n_fail;
  imem_loader_if #(.ADDR_W(8)) ld ();
  imem_loader #(.ADDR_W(8)) dut (.SYS_clk(clk), .SYS_rst(rst), .ld(ld));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] pack(input logic [7:0] q[$]);
    logic [31:0] v = 0;
    for (int i = 0; i < 4; i++) v = v * 256 + (i < q.size() ? 32'(q[i]) : 32'd0);
    return v;
  endfunction
  // model: 0 idle, 1 collecting, 2 write strobe, 3 release
  int m_mode, m_addr, m_wc;
  bit m_on, m_last, m_flush, m_err, m_wr_en;
  logic [7:0] m_bytes[$];
  logic [7:0] m_wr_addr;
  logic [31:0] m_wr_data;
  initial m_on = 0;
  always @(posedge clk) begin
    if (rst) begin
      m_mode = 0; m_bytes = {}; m_wc = 0; m_err = 0; m_wr_en = 0;
      m_wr_addr = 0; m_wr_data = 0; m_addr = 0; m_on = 1;
    end else begin
      m_wr_en = 0;
      case (m_mode)
        0: if (ld.LD_start) begin
          m_mode = 1; m_addr = int'(ld.LD_base_addr); m_wc = 0; m_err = 0; m_bytes = {}; m_last = 0;
        end
        1: begin
          if (ld.LD_byte_valid) m_bytes.push_back(ld.LD_byte);
          if (m_bytes.size() == 4 || (ld.LD_done && m_bytes.size() > 0)) begin
            m_flush = m_bytes.size() < 4; m_last = ld.LD_done; m_wr_en = 1;
            m_wr_addr = 8'(m_addr); m_wr_data = pack(m_bytes); m_mode = 2;
          end else if (ld.LD_done) m_mode = 3;
        end
        2: begin
          m_wc++; m_bytes = {};
          if (m_flush || m_addr == 255) begin m_err = 1; m_mode = 3; end
          else begin m_addr++; m_mode = m_last ? 3 : 1; end
        end
        default: m_mode = 0;
      endcase
    end
  end
  logic [7:0] wa[$];
  logic [31:0] wd[$];
  always @(negedge clk) begin
    if (m_on) begin
      chk("ready", ld.LD_byte_ready, m_mode == 1);
      chk("busy", ld.LD_busy, m_mode != 0);
      chk("hold", ld.LD_cpu_hold, m_mode != 0);
      chk("wr_en", ld.LD_wr_en, m_wr_en);
      chk("wr_addr", ld.LD_wr_addr, m_wr_addr);
      chk("wr_data", ld.LD_wr_data, m_wr_data);
      chk("word_count", ld.LD_word_count, m_wc);
      chk("err", ld.LD_err, m_err);
    end
    if (ld.LD_wr_en === 1'b1) begin wa.push_back(ld.LD_wr_addr); wd.push_back(ld.LD_wr_data); end
  end
  task automatic start_ld(input logic [7:0] base);
    ld.LD_start = 1; ld.LD_base_addr = base;
    @(negedge clk);
    ld.LD_start = 0;
  endtask
  task automatic send(input logic [7:0] b, input bit with_done, output bit ok);
    ld.LD_byte = b; ld.LD_byte_valid = 1; ok = 0;
    for (int t = 0; t < 8; t++) begin
      if (ld.LD_byte_ready) begin
        ok = 1; ld.LD_done = with_done;
        @(negedge clk);
        ld.LD_done = 0;
        break;
      end
      @(negedge clk);
    end
    ld.LD_byte_valid = 0;
  endtask
  task automatic pulse_done();
    for (int t = 0; t < 8 && !ld.LD_byte_ready; t++) @(negedge clk);
    ld.LD_done = 1;
    @(negedge clk);
    ld.LD_done = 0;
  endtask
  task automatic wait_idle();
    for (int t = 0; t < 12 && ld.LD_busy; t++) @(negedge clk);
    chk("idle_wait", ld.LD_busy, 0);
  endtask
  initial begin
    int n0, acc_n;
    bit ok, took;
    n_chk = 0; n_fail = 0;
    rst = 1; ld.LD_start = 0; ld.LD_base_addr = 0; ld.LD_byte = 0; ld.LD_byte_valid = 0; ld.LD_done = 0;
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_count", ld.LD_word_count, 0);
    chk("reset_wr_data", ld.LD_wr_data, 0);
    n0 = wa.size();
    start_ld(8'h10);
    send(8'h20, 0, ok); send(8'h08, 0, ok); send(8'h00, 0, ok); send(8'h05, 0, ok);
    pulse_done(); wait_idle();
    chk("full_nwr", wa.size() - n0, 1);
    chk("full_addr", wa[n0], 8'h10);
    chk("full_data", wd[n0], 32'h20080005);
    chk("full_count", ld.LD_word_count, 1);
    chk("full_err", ld.LD_err, 0);
    n0 = wa.size();
    start_ld(8'h00);
    for (int i = 0; i < 12; i++) send(8'(8'h11 * i), 0, ok);
    pulse_done(); wait_idle();
    chk("multi_nwr", wa.size() - n0, 3);
    chk("multi_a2", wa[n0 + 2], 8'h02);
    chk("multi_d1", wd[n0 + 1], 32'h445566_77);
    chk("multi_count", ld.LD_word_count, 3);
    n0 = wa.size();
    start_ld(8'h20);
    send(8'hAB, 0, ok); send(8'hCD, 0, ok);
    pulse_done(); wait_idle();
    chk("flush_data", wd[n0], 32'hABCD0000);
    chk("flush_err", ld.LD_err, 1);
    chk("flush_count", ld.LD_word_count, 1);
    n0 = wa.size(); acc_n = 0;
    start_ld(8'hFF);
    for (int i = 0; i < 8; i++) begin send(8'(i + 1), 0, ok); acc_n += int'(ok); end
    wait_idle();
    chk("ovf_accepted", acc_n, 4);
    chk("ovf_nwr", wa.size() - n0, 1);
    chk("ovf_addr", wa[n0], 8'hFF);
    chk("ovf_err", ld.LD_err, 1);
    n0 = wa.size();
    start_ld(8'h30);
    send(8'h01, 0, ok); send(8'h02, 0, ok); send(8'h03, 0, ok); send(8'h04, 1, ok);
    wait_idle();
    chk("simdone_nwr", wa.size() - n0, 1);
    chk("simdone_data", wd[n0], 32'h01020304);
    chk("simdone_count", ld.LD_word_count, 1);
    chk("simdone_err", ld.LD_err, 0);
    n0 = wa.size();
    start_ld(8'h40);
    send(8'hA1, 0, ok); send(8'hA2, 0, ok);
    start_ld(8'h80);
    send(8'hA3, 0, ok); send(8'hA4, 0, ok);
    send(8'hB1, 0, ok); send(8'hB2, 0, ok);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("rst_busy", ld.LD_busy, 0);
    chk("rst_hold", ld.LD_cpu_hold, 0);
    repeat (3) @(negedge clk);
    chk("restart_nwr", wa.size() - n0, 1);
    chk("restart_addr", wa[n0], 8'h40);
    took = 0;
    for (int c = 0; c < 3000; c++) begin
      if (!ld.LD_byte_valid || took) begin
        ld.LD_byte_valid = $urandom_range(0, 2) != 0;
        ld.LD_byte = 8'($urandom);
      end
      ld.LD_start = $urandom_range(0, 15) == 0;
      ld.LD_base_addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      ld.LD_done = $urandom_range(0, 12) == 0;
      rst = $urandom_range(0, 400) == 0;
      took = ld.LD_byte_valid && ld.LD_byte_ready && !rst;
      @(negedge clk);
    end
    ld.LD_byte_valid = 0; ld.LD_start = 0; ld.LD_done = 0; rst = 0;
    pulse_done(); wait_idle();
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
